// File: rtl/hidden_accumulator.sv
// rtl/hidden_accumulator.sv - RBM hidden-unit pre-activation: bias + sum(v_i*w_i), Q8.8, saturated
module hidden_accumulator #(
  parameter int INPUT_BITLENGTH = 16,
  parameter int N_VISIBLE       = 8,
  parameter int GUARD_BITS      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [INPUT_BITLENGTH-1:0] bias,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       v,
  input  logic [INPUT_BITLENGTH-1:0] w,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INPUT_BITLENGTH-1:0] sum,
  output logic                       busy
);

  localparam int ACC_W = INPUT_BITLENGTH + GUARD_BITS;
  localparam int CNT_W = (N_VISIBLE > 1) ? $clog2(N_VISIBLE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_VISIBLE - 1);

  // Symmetric clamp range: the most negative code is excluded so sigmoid can negate safely.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(GUARD_BITS+1){1'b0}}, {(INPUT_BITLENGTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [ACC_W-1:0]    bias_ext, w_ext, acc_next;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [INPUT_BITLENGTH-1:0] sum_q, sum_d, sat_val;

  assign bias_ext = {{GUARD_BITS{bias[INPUT_BITLENGTH-1]}}, bias};
  assign w_ext    = v ? {{GUARD_BITS{w[INPUT_BITLENGTH-1]}}, w} : '0;
  assign acc_next = acc_q + w_ext;

  always_comb begin
    sat_val = acc_next[INPUT_BITLENGTH-1:0];
    if (acc_next > SAT_MAX) begin
      sat_val = {1'b0, {(INPUT_BITLENGTH-1){1'b1}}};
    end else if (acc_next < SAT_MIN) begin
      sat_val = {1'b1, {(INPUT_BITLENGTH-2){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    sum_d     = sum_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = bias_ext;
          count_d = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = acc_next;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            sum_d   = sat_val;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        // start in this cycle is deliberately dropped; only IDLE accepts it.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sum  = sum_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_hidden_accumulator.sv
// tb/tb_hidden_accumulator.sv - randomized self-checking bench for hidden_accumulator
module tb_hidden_accumulator;

  localparam int IB = 16;
  localparam int NV = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [IB-1:0] bias;
  logic          in_valid;
  logic          in_ready;
  logic          v;
  logic [IB-1:0] w;
  logic          out_valid;
  logic          out_ready;
  logic [IB-1:0] sum;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic          v_arr [NV];
  logic [IB-1:0] w_arr [NV];

  hidden_accumulator #(.INPUT_BITLENGTH(IB), .N_VISIBLE(NV), .GUARD_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .v(v), .w(w),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer sum of selected weights, clamped to +/-0x7FFF.
  function automatic logic [IB-1:0] model(input logic [IB-1:0] b);
    int acc;
    acc = int'($signed(b));
    for (int i = 0; i < NV; i++)
      if (v_arr[i]) acc += int'($signed(w_arr[i]));
    if (acc > 32767) acc = 32767;
    if (acc < -32767) acc = -32767;
    return acc[IB-1:0];
  endfunction

  task automatic fill(input logic vv, input logic [IB-1:0] ww);
    for (int i = 0; i < NV; i++) begin
      v_arr[i] = vv;
      w_arr[i] = ww;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NV; i++) begin
      v_arr[i] = 1'($urandom);
      w_arr[i] = IB'($urandom);
    end
  endtask

  task automatic run_txn(input string tag, input logic [IB-1:0] b, input int max_gap,
                         input int wait_cycles, input bit start_in_wait);
    logic [IB-1:0] exp;
    int gaps;
    exp   = model(b);
    start = 1'b1;
    bias  = b;
    step();
    start = 1'b0;
    bias  = IB'($urandom);
    check({tag, ":busy_start"}, busy, 1);
    check({tag, ":in_ready_accum"}, in_ready, 1);
    for (int i = 0; i < NV; i++) begin
      gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      repeat (gaps) begin
        in_valid = 1'b0;
        v = 1'($urandom);
        w = IB'($urandom);
        step();
      end
      in_valid = 1'b1;
      v = v_arr[i];
      w = w_arr[i];
      if (i == NV - 1) check({tag, ":out_valid_early"}, out_valid, 0);
      step();
    end
    in_valid = 1'b0;
    v = 1'($urandom);
    w = IB'($urandom);
    check({tag, ":out_valid"}, out_valid, 1);
    check({tag, ":sum"}, sum, exp);
    for (int k = 0; k < wait_cycles; k++) begin
      out_ready = 1'b0;
      start     = start_in_wait;
      bias      = IB'($urandom);
      step();
      check({tag, ":sum_hold"}, sum, exp);
      check({tag, ":in_ready_done"}, in_ready, 0);
      check({tag, ":out_valid_hold"}, out_valid, 1);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    step();
    out_ready = 1'b0;
    start     = 1'b0;
    check({tag, ":out_valid_drop"}, out_valid, 0);
    check({tag, ":busy_idle"}, busy, 0);
    step();
    check({tag, ":no_capture"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; bias = '0; in_valid = 1'b0;
    v = 1'b0; w = '0; out_ready = 1'b0;

    repeat (2) begin
      start = 1'($urandom); bias = IB'($urandom); in_valid = 1'($urandom);
      v = 1'($urandom); w = IB'($urandom); out_ready = 1'($urandom);
      step();
    end
    check("rst:in_ready", in_ready, 0);
    check("rst:out_valid", out_valid, 0);
    check("rst:busy", busy, 0);
    check("rst:sum", sum, 16'h0000);
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    check("rst:idle_after", busy, 0);

    fill(1'b1, 16'h0080);
    run_txn("nominal", 16'h0100, 0, 0, 1'b0);
    check("nominal:model", model(16'h0100), 16'h0500);

    fill(1'b0, 16'h7FFF);
    v_arr[0] = 1'b1; w_arr[0] = 16'h0040;
    v_arr[1] = 1'b1; w_arr[1] = 16'h0040;
    run_txn("mask", 16'h0000, 0, 0, 1'b0);

    fill(1'b1, 16'h1000);
    run_txn("sat_pos", 16'h7000, 0, 1, 1'b0);
    fill(1'b1, 16'hF000);
    run_txn("sat_neg", 16'h9000, 0, 1, 1'b0);

    fill_random();
    run_txn("flow", IB'($urandom), 3, 5, 1'b1);

    start = 1'b1; bias = 16'h1234;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; v = 1'b1; w = 16'h0100;
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    check("midrst:busy", busy, 0);
    check("midrst:in_ready", in_ready, 0);
    check("midrst:sum", sum, 16'h0000);
    fill_random();
    run_txn("midrst_after", IB'($urandom), 0, 0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      fill_random();
      if (t % 4 == 0) fill(1'b1, IB'($urandom));
      run_txn("rand", IB'($urandom), $urandom_range(0, 2), $urandom_range(0, 4),
              1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
